// File: rtl/cluster_link_pkg.sv
// Shared link framing types: cluster/frame layouts, K-character constants and word builders.
// Link word: header = K28.5 + frame summary, cluster = 14-bit payload, idle = K28.1.
package cluster_link_pkg;

   localparam int N_CLUSTERS = 8;
   localparam logic [7:0] K_HDR = 8'hBC;
   localparam logic [7:0] K_IDLE = 8'h3C;
   localparam logic [15:0] IDLE_WORD = {K_IDLE, 8'h00};

   typedef struct packed {
      logic [2:0]  size;
      logic [10:0] address;
   } cluster_t;

   typedef struct packed {
      cluster_t [N_CLUSTERS-1:0] clusters;
      logic [3:0]                ncl;
      logic                      ovf;
      logic                      bc0;
      logic [1:0]                seq;
   } frame_t;

   function automatic logic [15:0] header_word(input frame_t f);
      return {K_HDR, f.ovf, f.bc0, f.ncl, f.seq};
   endfunction

   function automatic logic [15:0] cluster_word(input cluster_t c);
      return {2'b00, c};
   endfunction

endpackage

// File: rtl/frame_fifo.sv
// Synchronous show-ahead FIFO; rd_data is the head entry, full/empty derive from a registered count.
// A write is only legal when not full or together with a read; the caller enforces this.
module frame_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + AW'(1);
         if (rd) rd_ptr <= rd_ptr + AW'(1);
         case ({wr, rd})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: ;
         endcase
      end
   end

   // When full, a simultaneous pop reads the old head before this write lands on it.
   always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);

endmodule

// File: rtl/cluster_link_framer.sv
// Frames 8 clusters/BX into a 16-bit K-coded word stream; header lands 2 cycles after the strobe.
// Frames queue in a small FIFO; a refused write bumps drop_cnt and flags ovf on the next accepted frame.
module cluster_link_framer
   import cluster_link_pkg::*;
#(
   parameter int unsigned N_STRIPS       = 1536,
   parameter int          FIFO_DEPTH     = 4,
   parameter bit          SUPPRESS_EMPTY = 1'b1
) (
   input  logic        clock4x,
   input  logic        global_reset_n,
   input  logic        clusters_valid,
   input  logic [13:0] cluster0,
   input  logic [13:0] cluster1,
   input  logic [13:0] cluster2,
   input  logic [13:0] cluster3,
   input  logic [13:0] cluster4,
   input  logic [13:0] cluster5,
   input  logic [13:0] cluster6,
   input  logic [13:0] cluster7,
   input  logic        overflow,
   input  logic        bc0,
   output logic [15:0] tx_data,
   output logic [1:0]  tx_isk,
   output logic [15:0] drop_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA} state_t;

   state_t   state, state_nx;
   logic [2:0] k, k_nx;
   cluster_t cl_in [N_CLUSTERS];
   frame_t   cap, head;
   cluster_t [N_CLUSTERS-1:0] cur_cl;
   logic [3:0]  cur_ncl;
   logic [3:0]  ncl;
   logic [1:0]  seq;
   logic        sticky_drop;
   logic        wr_req, accept, pop;
   logic        fifo_full, fifo_empty;
   logic        frame_done;
   logic [15:0] word_nx;
   logic [1:0]  isk_nx;

   assign cl_in[0] = cluster0;
   assign cl_in[1] = cluster1;
   assign cl_in[2] = cluster2;
   assign cl_in[3] = cluster3;
   assign cl_in[4] = cluster4;
   assign cl_in[5] = cluster5;
   assign cl_in[6] = cluster6;
   assign cl_in[7] = cluster7;

   // Compact valid clusters into the low slots, keeping packer priority order.
   always_comb begin
      cap = '0;
      ncl = '0;
      for (int i = 0; i < N_CLUSTERS; i++) begin
         if (32'(cl_in[i].address) < N_STRIPS) begin
            cap.clusters[ncl[2:0]] = cl_in[i];
            ncl = ncl + 4'd1;
         end
      end
      cap.ncl = ncl;
      cap.ovf = overflow | sticky_drop;
      cap.bc0 = bc0;
      cap.seq = seq;
   end

   assign wr_req = clusters_valid && !(SUPPRESS_EMPTY && ncl == 4'd0 && !overflow && !bc0);
   assign accept = wr_req && (!fifo_full || pop);

   frame_fifo #(
      .WIDTH ($bits(frame_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clock4x),
      .rst_n   (global_reset_n),
      .wr      (accept),
      .wr_data (cap),
      .rd      (pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // tx_data always shows the word belonging to the current state.
   always_comb begin
      state_nx   = state;
      k_nx       = k;
      pop        = 1'b0;
      word_nx    = IDLE_WORD;
      isk_nx     = 2'b10;
      frame_done = 1'b1;
      case (state)
         S_HEADER: frame_done = (cur_ncl == 4'd0);
         S_DATA:   frame_done = ({1'b0, k} == cur_ncl - 4'd1);
         default:  frame_done = 1'b1;
      endcase
      if (frame_done) begin
         if (!fifo_empty) begin
            pop      = 1'b1;
            state_nx = S_HEADER;
            word_nx  = header_word(head);
         end else begin
            state_nx = S_IDLE;
         end
      end else if (state == S_HEADER) begin
         state_nx = S_DATA;
         k_nx     = '0;
         word_nx  = cluster_word(cur_cl[0]);
         isk_nx   = 2'b00;
      end else begin
         k_nx    = k + 3'd1;
         word_nx = cluster_word(cur_cl[k + 3'd1]);
         isk_nx  = 2'b00;
      end
   end

   always_ff @(posedge clock4x) begin
      if (!global_reset_n) begin
         state <= S_IDLE;
         k     <= '0;
      end else begin
         state <= state_nx;
         k     <= k_nx;
      end
   end

   always_ff @(posedge clock4x) begin
      if (!global_reset_n) begin
         tx_data     <= IDLE_WORD;
         tx_isk      <= 2'b10;
         cur_cl      <= '0;
         cur_ncl     <= '0;
         seq         <= '0;
         sticky_drop <= 1'b0;
         drop_cnt    <= '0;
      end else begin
         tx_data <= word_nx;
         tx_isk  <= isk_nx;
         if (pop) begin
            cur_cl  <= head.clusters;
            cur_ncl <= head.ncl;
         end
         if (accept) begin
            seq         <= seq + 2'd1;
            sticky_drop <= 1'b0;
         end else if (wr_req) begin
            sticky_drop <= 1'b1;
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end

endmodule
